// File: rtl/ufm_prog_ctrl_pkg.sv
// Shared sl28 CSR definitions for the UFM program sequencer: register offsets,
// command/status bit positions and FSM state encodings.
package ufm_prog_ctrl_pkg;

    localparam logic [4:0] R_UFMP_DATA_HI = 5'd0;
    localparam logic [4:0] R_UFMP_DATA_LO = 5'd1;
    localparam logic [4:0] R_UFMP_CMD     = 5'd2;
    localparam logic [4:0] R_UFMP_STATUS  = 5'd3;

    localparam int CMD_PROG   = 0;
    localparam int CMD_ERASE  = 1;
    localparam int CMD_VERIFY = 2;

    localparam int ST_DONE        = 0;
    localparam int ST_ERR_VERIFY  = 1;
    localparam int ST_ERR_TIMEOUT = 2;
    localparam int ST_UFM_BUSY    = 6;
    localparam int ST_BUSY        = 7;

    localparam logic [15:0] ERASED_WORD = 16'hffff;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_SHIFT_LO     = 4'd1,
        S_SHIFT_HI     = 4'd2,
        S_PROG_ASSERT  = 4'd3,
        S_ERASE_ASSERT = 4'd4,
        S_WAIT_IDLE    = 4'd5,
        S_LOAD_LO      = 4'd6,
        S_LOAD_HI      = 4'd7,
        S_RD_SAMPLE    = 4'd8,
        S_RD_CLK       = 4'd9,
        S_CMP          = 4'd10,
        S_FINISH       = 4'd11
    } state_t;

endpackage

// File: rtl/ufm_prog_ctrl_busy_timer.sv
// Per-phase watchdog for the UFM busy handshake: counts enabled cycles since the
// last clear and flags expiry on the LIMIT-th cycle.
module ufm_busy_timer #(
    parameter logic [19:0] LIMIT = 20'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [19:0] count;

    // Expiry is seen during the LIMIT-th enabled cycle, so the phase lasts exactly LIMIT cycles.
    assign expired = (count == LIMIT - 20'd1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 20'd0;
        end else if (en && !expired) begin
            count <= count + 20'd1;
        end
    end

endmodule

// File: rtl/ufm_prog_ctrl.sv
// UFM erase/program/verify sequencer: latches a 16-bit word and a command from
// the CSR window, then drives the UFM data-register pins through the full cycle.
module ufm_prog_ctrl
    import ufm_prog_ctrl_pkg::*;
#(
    parameter logic [4:0]  BASE_ADDR    = 5'h4,
    parameter logic [19:0] BUSY_TIMEOUT = 20'd1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       en,
    input  logic       ufm_busy,
    input  logic       ufm_drdout,
    output logic       ufm_drclk,
    output logic       ufm_drshft,
    output logic       ufm_drdin,
    output logic       ufm_program,
    output logic       ufm_erase,
    output logic       active
);

    state_t      state;
    logic [15:0] data;
    logic [15:0] word;
    logic [15:0] shreg;
    logic [3:0]  cnt;
    logic        verify_pend;
    logic        erased;
    logic        done_flag;
    logic        err_verify;
    logic        err_timeout;
    logic        busy_flag;
    logic        cmd_wr;
    logic        cmd_ok;
    logic        stat_wr;
    logic        timed;
    logic        tmr_clr;
    logic        tmr_expired;

    assign busy_flag = (state != S_IDLE);
    assign cmd_wr    = csr_we && (csr_a == BASE_ADDR + R_UFMP_CMD);
    assign stat_wr   = csr_we && (csr_a == BASE_ADDR + R_UFMP_STATUS);
    assign cmd_ok    = cmd_wr && en && (state == S_IDLE) && (|csr_di[2:0])
                       && !(csr_di[CMD_PROG] && csr_di[CMD_ERASE]);

    // The timer restarts on every entry into an assert or wait phase; the only
    // assert->wait transition is the busy rise, so that is folded into the clear.
    assign timed   = (state == S_PROG_ASSERT) || (state == S_ERASE_ASSERT) || (state == S_WAIT_IDLE);
    assign tmr_clr = !timed || (((state == S_PROG_ASSERT) || (state == S_ERASE_ASSERT)) && ufm_busy);

    ufm_busy_timer #(.LIMIT(BUSY_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (timed),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= 16'hffff;
        end else if (csr_we && (csr_a == BASE_ADDR + R_UFMP_DATA_HI)) begin
            data[15:8] <= csr_di;
        end else if (csr_we && (csr_a == BASE_ADDR + R_UFMP_DATA_LO)) begin
            data[7:0] <= csr_di;
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (csr_a == BASE_ADDR + R_UFMP_DATA_HI) begin
            csr_do = data[15:8];
        end else if (csr_a == BASE_ADDR + R_UFMP_DATA_LO) begin
            csr_do = data[7:0];
        end else if (csr_a == BASE_ADDR + R_UFMP_STATUS) begin
            csr_do[ST_BUSY]        = busy_flag;
            csr_do[ST_UFM_BUSY]    = ufm_busy;
            csr_do[ST_ERR_TIMEOUT] = err_timeout;
            csr_do[ST_ERR_VERIFY]  = err_verify;
            csr_do[ST_DONE]        = done_flag;
        end
    end

    // Pin outputs are assigned on the transition into a state, so they are valid
    // for the whole time the FSM sits in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            word        <= 16'hffff;
            shreg       <= 16'h0000;
            cnt         <= 4'd0;
            verify_pend <= 1'b0;
            erased      <= 1'b0;
            done_flag   <= 1'b0;
            err_verify  <= 1'b0;
            err_timeout <= 1'b0;
            ufm_drclk   <= 1'b1;
            ufm_drshft  <= 1'b1;
            ufm_drdin   <= 1'b0;
            ufm_program <= 1'b0;
            ufm_erase   <= 1'b0;
            active      <= 1'b0;
        end else begin
            if (stat_wr) begin
                done_flag   <= 1'b0;
                err_verify  <= 1'b0;
                err_timeout <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (cmd_ok) begin
                        word        <= data;
                        verify_pend <= csr_di[CMD_VERIFY];
                        erased      <= csr_di[CMD_ERASE];
                        active      <= 1'b1;
                        if (csr_di[CMD_ERASE]) begin
                            ufm_erase <= 1'b1;
                            state     <= S_ERASE_ASSERT;
                        end else if (csr_di[CMD_PROG]) begin
                            cnt        <= 4'd15;
                            ufm_drclk  <= 1'b0;
                            ufm_drshft <= 1'b1;
                            ufm_drdin  <= data[15];
                            state      <= S_SHIFT_LO;
                        end else begin
                            ufm_drclk  <= 1'b0;
                            ufm_drshft <= 1'b0;
                            state      <= S_LOAD_LO;
                        end
                    end
                end
                S_SHIFT_LO: begin
                    ufm_drclk <= 1'b1;
                    state     <= S_SHIFT_HI;
                end
                S_SHIFT_HI: begin
                    if (cnt == 4'd0) begin
                        ufm_program <= 1'b1;
                        state       <= S_PROG_ASSERT;
                    end else begin
                        cnt       <= cnt - 4'd1;
                        ufm_drclk <= 1'b0;
                        ufm_drdin <= word[cnt - 4'd1];
                        state     <= S_SHIFT_LO;
                    end
                end
                S_PROG_ASSERT: begin
                    if (ufm_busy) begin
                        ufm_program <= 1'b0;
                        state       <= S_WAIT_IDLE;
                    end else if (tmr_expired) begin
                        ufm_program <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= S_FINISH;
                    end
                end
                S_ERASE_ASSERT: begin
                    if (ufm_busy) begin
                        ufm_erase <= 1'b0;
                        state     <= S_WAIT_IDLE;
                    end else if (tmr_expired) begin
                        ufm_erase   <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= S_FINISH;
                    end
                end
                S_WAIT_IDLE: begin
                    if (!ufm_busy) begin
                        if (verify_pend) begin
                            ufm_drclk  <= 1'b0;
                            ufm_drshft <= 1'b0;
                            state      <= S_LOAD_LO;
                        end else begin
                            state <= S_FINISH;
                        end
                    end else if (tmr_expired) begin
                        err_timeout <= 1'b1;
                        state       <= S_FINISH;
                    end
                end
                S_LOAD_LO: begin
                    ufm_drclk <= 1'b1;
                    cnt       <= 4'd15;
                    state     <= S_LOAD_HI;
                end
                S_LOAD_HI: begin
                    ufm_drshft <= 1'b1;
                    ufm_drclk  <= 1'b0;
                    state      <= S_RD_SAMPLE;
                end
                S_RD_SAMPLE: begin
                    shreg <= {shreg[14:0], ufm_drdout};
                    if (cnt == 4'd0) begin
                        state <= S_CMP;
                    end else begin
                        ufm_drclk <= 1'b1;
                        state     <= S_RD_CLK;
                    end
                end
                S_RD_CLK: begin
                    cnt       <= cnt - 4'd1;
                    ufm_drclk <= 1'b0;
                    state     <= S_RD_SAMPLE;
                end
                S_CMP: begin
                    err_verify <= (shreg != (erased ? ERASED_WORD : word));
                    state      <= S_FINISH;
                end
                S_FINISH: begin
                    done_flag   <= 1'b1;
                    ufm_drclk   <= 1'b1;
                    ufm_drshft  <= 1'b1;
                    ufm_drdin   <= 1'b0;
                    ufm_program <= 1'b0;
                    ufm_erase   <= 1'b0;
                    active      <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ufm_prog_ctrl.sv
// Directed bench for ufm_prog_ctrl with a behavioural UFM model (one-word array
// at the loader-preset address, busy rising a few cycles after a strobe).
module tb_ufm_prog_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] csr_a = 5'd0;
    logic [7:0] csr_di = 8'd0;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic       en = 1'b1;
    logic       ufm_busy = 1'b0;
    logic       ufm_drdout;
    logic       ufm_drclk, ufm_drshft, ufm_drdin, ufm_program, ufm_erase, active;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] m_reg = 16'h0000;
    logic [15:0] m_array = 16'h0000;
    logic [15:0] force_val = 16'h0000;
    logic        force_store = 1'b0;
    logic        hold_busy_low = 1'b0;
    logic        strobe_q = 1'b0;
    logic        prog_q = 1'b0;
    logic        erase_q = 1'b0;
    int          bcnt = 0;
    int          prog_pulses = 0;
    int          erase_pulses = 0;
    int          prog_cycles = 0;
    logic        din_log[$];

    ufm_prog_ctrl #(.BASE_ADDR(5'h4), .BUSY_TIMEOUT(20'd16)) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_a       (csr_a),
        .csr_di      (csr_di),
        .csr_we      (csr_we),
        .csr_do      (csr_do),
        .en          (en),
        .ufm_busy    (ufm_busy),
        .ufm_drdout  (ufm_drdout),
        .ufm_drclk   (ufm_drclk),
        .ufm_drshft  (ufm_drshft),
        .ufm_drdin   (ufm_drdin),
        .ufm_program (ufm_program),
        .ufm_erase   (ufm_erase),
        .active      (active)
    );

    always #5 clk = ~clk;

    // UFM model: strobe edges, busy timing (rise 3 cycles after strobe, 5 cycles high).
    always @(posedge clk) begin
        strobe_q <= ufm_program | ufm_erase;
        prog_q   <= ufm_program;
        erase_q  <= ufm_erase;
        if (ufm_program === 1'b1) prog_cycles <= prog_cycles + 1;
        if (ufm_program === 1'b1 && !prog_q) begin
            prog_pulses <= prog_pulses + 1;
            m_array     <= force_store ? force_val : m_reg;
        end
        if (ufm_erase === 1'b1 && !erase_q) begin
            erase_pulses <= erase_pulses + 1;
            m_array      <= 16'hffff;
        end
        if ((ufm_program | ufm_erase) === 1'b1 && !strobe_q && !hold_busy_low) begin
            bcnt <= 1;
        end else if (bcnt != 0) begin
            if (bcnt == 3) ufm_busy <= 1'b1;
            if (bcnt == 8) begin
                ufm_busy <= 1'b0;
                bcnt     <= 0;
            end else begin
                bcnt <= bcnt + 1;
            end
        end
    end

    always @(posedge ufm_drclk) begin
        if (ufm_drshft === 1'b1) begin
            m_reg <= {m_reg[14:0], ufm_drdin};
            din_log.push_back(ufm_drdin);
        end else begin
            m_reg <= m_array;
        end
    end

    assign ufm_drdout = m_reg[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        csr_a = a;
        #1 d = csr_do;
    endtask

    task automatic clear_model();
        @(negedge clk);
        prog_pulses  = 0;
        erase_pulses = 0;
        prog_cycles  = 0;
        din_log.delete();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (active !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (active !== 1'b0) begin
            $display("FAIL %s_idle_timeout: active=%b after %0d cycles, required 0", name, active, n);
            n_fail++;
        end
    endtask

    function automatic logic [15:0] din_word();
        logic [15:0] w = 16'h0000;
        foreach (din_log[i]) w = {w[14:0], din_log[i]};
        return w;
    endfunction

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (ufm_drclk !== 1'b1) begin $display("FAIL reset_drclk: got %b want 1", ufm_drclk); n_fail++; end
        n_cmp++; if (ufm_drshft !== 1'b1) begin $display("FAIL reset_drshft: got %b want 1", ufm_drshft); n_fail++; end
        n_cmp++; if (ufm_drdin !== 1'b0) begin $display("FAIL reset_drdin: got %b want 0", ufm_drdin); n_fail++; end
        n_cmp++; if (ufm_program !== 1'b0) begin $display("FAIL reset_program: got %b want 0", ufm_program); n_fail++; end
        n_cmp++; if (ufm_erase !== 1'b0) begin $display("FAIL reset_erase: got %b want 0", ufm_erase); n_fail++; end
        n_cmp++; if (active !== 1'b0) begin $display("FAIL reset_active: got %b want 0", active); n_fail++; end
        csr_read(5'h4, d);
        n_cmp++; if (d !== 8'hff) begin $display("FAIL reset_data_hi: got %h want ff", d); n_fail++; end
        csr_read(5'h5, d);
        n_cmp++; if (d !== 8'hff) begin $display("FAIL reset_data_lo: got %h want ff", d); n_fail++; end
        csr_read(5'h7, d);
        n_cmp++; if (d !== 8'h00) begin $display("FAIL reset_status: got %h want 00", d); n_fail++; end
    endtask

    task automatic test_prog();
        logic [7:0] d;
        clear_model();
        csr_write(5'h4, 8'hA5);
        csr_write(5'h5, 8'h5A);
        csr_write(5'h6, 8'h01);
        wait_idle("prog");
        n_cmp++; if (din_log.size() != 16) begin $display("FAIL prog_shift_count: got %0d want 16", din_log.size()); n_fail++; end
        n_cmp++; if (din_word() !== 16'hA55A) begin $display("FAIL prog_drdin_seq: got %h want a55a", din_word()); n_fail++; end
        n_cmp++; if (prog_pulses != 1) begin $display("FAIL prog_pulses: got %0d want 1", prog_pulses); n_fail++; end
        n_cmp++; if (prog_cycles != 5) begin $display("FAIL prog_until_busy: got %0d want 5", prog_cycles); n_fail++; end
        n_cmp++; if (erase_pulses != 0) begin $display("FAIL prog_no_erase: got %0d want 0", erase_pulses); n_fail++; end
        n_cmp++; if (m_array !== 16'hA55A) begin $display("FAIL prog_array: got %h want a55a", m_array); n_fail++; end
        csr_read(5'h7, d);
        n_cmp++; if (d !== 8'h01) begin $display("FAIL prog_status: got %h want 01", d); n_fail++; end
        csr_write(5'h7, 8'h00);
        csr_read(5'h7, d);
        n_cmp++; if (d !== 8'h00) begin $display("FAIL status_clear: got %h want 00", d); n_fail++; end
    endtask

    task automatic test_verify_fail();
        logic [7:0] d;
        clear_model();
        force_store = 1'b1;
        force_val   = 16'hA55B;
        csr_write(5'h6, 8'h05);
        wait_idle("verify_fail");
        force_store = 1'b0;
        n_cmp++; if (m_array !== 16'hA55B) begin $display("FAIL vfail_array: got %h want a55b", m_array); n_fail++; end
        n_cmp++; if (prog_pulses != 1) begin $display("FAIL vfail_pulses: got %0d want 1", prog_pulses); n_fail++; end
        csr_read(5'h7, d);
        n_cmp++; if (d !== 8'h03) begin $display("FAIL vfail_status: got %h want 03", d); n_fail++; end
        csr_write(5'h7, 8'h00);
    endtask

    task automatic test_erase_verify();
        logic [7:0] d;
        clear_model();
        csr_write(5'h6, 8'h06);
        wait_idle("erase_verify");
        n_cmp++; if (erase_pulses != 1) begin $display("FAIL erase_pulses: got %0d want 1", erase_pulses); n_fail++; end
        n_cmp++; if (prog_pulses != 0) begin $display("FAIL erase_no_prog: got %0d want 0", prog_pulses); n_fail++; end
        n_cmp++; if (m_array !== 16'hffff) begin $display("FAIL erase_array: got %h want ffff", m_array); n_fail++; end
        csr_read(5'h7, d);
        n_cmp++; if (d !== 8'h01) begin $display("FAIL erase_status: got %h want 01", d); n_fail++; end
        csr_write(5'h7, 8'h00);
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        clear_model();
        hold_busy_low = 1'b1;
        csr_write(5'h6, 8'h01);
        wait_idle("timeout");
        hold_busy_low = 1'b0;
        n_cmp++; if (prog_cycles != 16) begin $display("FAIL timeout_prog_len: got %0d want 16", prog_cycles); n_fail++; end
        n_cmp++; if (ufm_program !== 1'b0) begin $display("FAIL timeout_prog_low: got %b want 0", ufm_program); n_fail++; end
        csr_read(5'h7, d);
        n_cmp++; if (d !== 8'h05) begin $display("FAIL timeout_status: got %h want 05", d); n_fail++; end
        csr_write(5'h7, 8'h00);
    endtask

    task automatic test_ignored();
        logic [7:0] d;
        clear_model();
        en = 1'b0;
        csr_write(5'h6, 8'h01);
        repeat (4) @(negedge clk);
        en = 1'b1;
        n_cmp++; if (active !== 1'b0) begin $display("FAIL en_low_active: got %b want 0", active); n_fail++; end
        n_cmp++; if (prog_pulses != 0) begin $display("FAIL en_low_pulses: got %0d want 0", prog_pulses); n_fail++; end
        csr_write(5'h6, 8'h03);
        repeat (4) @(negedge clk);
        n_cmp++; if (active !== 1'b0) begin $display("FAIL prog_erase_active: got %b want 0", active); n_fail++; end
        n_cmp++; if (erase_pulses != 0) begin $display("FAIL prog_erase_pulses: got %0d want 0", erase_pulses); n_fail++; end
        csr_read(5'h7, d);
        n_cmp++; if (d !== 8'h00) begin $display("FAIL ignored_status: got %h want 00", d); n_fail++; end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        clear_model();
        csr_write(5'h6, 8'h01);
        csr_read(5'h7, d);
        n_cmp++; if (d !== 8'h80) begin $display("FAIL b2b_busy_status: got %h want 80", d); n_fail++; end
        csr_write(5'h4, 8'h12);
        csr_write(5'h5, 8'h34);
        csr_write(5'h6, 8'h01);
        wait_idle("b2b");
        n_cmp++; if (din_word() !== 16'hA55A) begin $display("FAIL b2b_word_in_flight: got %h want a55a", din_word()); n_fail++; end
        n_cmp++; if (prog_pulses != 1) begin $display("FAIL b2b_pulses: got %0d want 1", prog_pulses); n_fail++; end
        n_cmp++; if (m_array !== 16'hA55A) begin $display("FAIL b2b_array: got %h want a55a", m_array); n_fail++; end
        csr_read(5'h4, d);
        n_cmp++; if (d !== 8'h12) begin $display("FAIL b2b_data_hi: got %h want 12", d); n_fail++; end
        csr_read(5'h5, d);
        n_cmp++; if (d !== 8'h34) begin $display("FAIL b2b_data_lo: got %h want 34", d); n_fail++; end
        csr_read(5'h7, d);
        n_cmp++; if (d !== 8'h01) begin $display("FAIL b2b_status: got %h want 01", d); n_fail++; end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        clear_model();
        csr_write(5'h6, 8'h01);
        n_cmp++; if (ufm_drclk !== 1'b0) begin $display("FAIL mid_shift_lo: drclk got %b want 0", ufm_drclk); n_fail++; end
        @(negedge clk);
        n_cmp++; if (ufm_drclk !== 1'b1 || active !== 1'b1) begin
            $display("FAIL mid_shift_hi: drclk=%b active=%b want 1 1", ufm_drclk, active); n_fail++;
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (ufm_drclk !== 1'b1) begin $display("FAIL mid_rst_drclk: got %b want 1", ufm_drclk); n_fail++; end
        n_cmp++; if (ufm_drshft !== 1'b1) begin $display("FAIL mid_rst_drshft: got %b want 1", ufm_drshft); n_fail++; end
        n_cmp++; if (ufm_program !== 1'b0) begin $display("FAIL mid_rst_program: got %b want 0", ufm_program); n_fail++; end
        n_cmp++; if (active !== 1'b0) begin $display("FAIL mid_rst_active: got %b want 0", active); n_fail++; end
        rst = 1'b0;
        csr_read(5'h7, d);
        n_cmp++; if (d !== 8'h00) begin $display("FAIL mid_rst_status: got %h want 00", d); n_fail++; end
        csr_read(5'h4, d);
        n_cmp++; if (d !== 8'hff) begin $display("FAIL mid_rst_data_hi: got %h want ff", d); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_prog();
        test_verify_fail();
        test_erase_verify();
        test_timeout();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
